// File: rtl/cb_channel_pair.sv
// Connection-box tile: paired vertical/horizontal routing channels with
// straight-through tracks, scan-configured CLB taps and one config chain per channel.
module cb_channel_pair (
  input  logic       scan_clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic       scan_in_vc,
  output logic       scan_out_vc,
  input  logic       scan_in_hc,
  output logic       scan_out_hc,
  input  logic [3:0] top_in,
  input  logic [3:0] bottom_in,
  output logic [3:0] top_out,
  output logic [3:0] bottom_out,
  input  logic [3:0] left_in,
  input  logic [3:0] right_in,
  output logic [3:0] left_out,
  output logic [3:0] right_out,
  output logic       left_clb_in1,
  output logic       right_clb_in3,
  output logic       top_clb_in2,
  output logic       bottom_clb_in0
);

  logic [3:0] vc_cfg;
  logic [3:0] hc_cfg;

  // Both chains share scan_en and shift in lockstep; reset wins over shifting.
  always_ff @(posedge scan_clk) begin
    if (rst) begin
      vc_cfg <= '0;
      hc_cfg <= '0;
    end else if (scan_en) begin
      vc_cfg <= {vc_cfg[2:0], scan_in_vc};
      hc_cfg <= {hc_cfg[2:0], scan_in_hc};
    end
  end

  assign scan_out_vc = vc_cfg[3];
  assign scan_out_hc = hc_cfg[3];

  assign bottom_out = top_in;
  assign top_out    = bottom_in;
  assign right_out  = left_in;
  assign left_out   = right_in;

  always_comb begin
    left_clb_in1 = 1'b0;
    case (vc_cfg[1:0])
      2'd0: left_clb_in1 = bottom_in[0];
      2'd1: left_clb_in1 = top_in[0];
      2'd2: left_clb_in1 = bottom_in[2];
      2'd3: left_clb_in1 = top_in[2];
      default: left_clb_in1 = 1'b0;
    endcase
  end

  always_comb begin
    right_clb_in3 = 1'b0;
    case (vc_cfg[3:2])
      2'd0: right_clb_in3 = bottom_in[1];
      2'd1: right_clb_in3 = top_in[1];
      2'd2: right_clb_in3 = bottom_in[3];
      2'd3: right_clb_in3 = top_in[3];
      default: right_clb_in3 = 1'b0;
    endcase
  end

  always_comb begin
    bottom_clb_in0 = 1'b0;
    case (hc_cfg[1:0])
      2'd0: bottom_clb_in0 = right_in[1];
      2'd1: bottom_clb_in0 = left_in[1];
      2'd2: bottom_clb_in0 = right_in[3];
      2'd3: bottom_clb_in0 = left_in[3];
      default: bottom_clb_in0 = 1'b0;
    endcase
  end

  always_comb begin
    top_clb_in2 = 1'b0;
    case (hc_cfg[3:2])
      2'd0: top_clb_in2 = right_in[0];
      2'd1: top_clb_in2 = left_in[0];
      2'd2: top_clb_in2 = right_in[2];
      2'd3: top_clb_in2 = left_in[2];
      default: top_clb_in2 = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cb_channel_pair.sv
// Self-checking bench for cb_channel_pair: a history-of-shifted-bits model
// checked every cycle, plus hand-computed literal expectations.
module tb_cb_channel_pair;

  logic       scan_clk;
  logic       rst;
  logic       scan_en;
  logic       scan_in_vc;
  logic       scan_out_vc;
  logic       scan_in_hc;
  logic       scan_out_hc;
  logic [3:0] top_in;
  logic [3:0] bottom_in;
  logic [3:0] top_out;
  logic [3:0] bottom_out;
  logic [3:0] left_in;
  logic [3:0] right_in;
  logic [3:0] left_out;
  logic [3:0] right_out;
  logic       left_clb_in1;
  logic       right_clb_in3;
  logic       top_clb_in2;
  logic       bottom_clb_in0;

  cb_channel_pair dut (
    .scan_clk       (scan_clk),
    .rst            (rst),
    .scan_en        (scan_en),
    .scan_in_vc     (scan_in_vc),
    .scan_out_vc    (scan_out_vc),
    .scan_in_hc     (scan_in_hc),
    .scan_out_hc    (scan_out_hc),
    .top_in         (top_in),
    .bottom_in      (bottom_in),
    .top_out        (top_out),
    .bottom_out     (bottom_out),
    .left_in        (left_in),
    .right_in       (right_in),
    .left_out       (left_out),
    .right_out      (right_out),
    .left_clb_in1   (left_clb_in1),
    .right_clb_in3  (right_clb_in3),
    .top_clb_in2    (top_clb_in2),
    .bottom_clb_in0 (bottom_clb_in0)
  );

  initial scan_clk = 1'b0;
  always #5 scan_clk = ~scan_clk;

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  // Model: remember the bits shifted since the last reset (newest last).
  bit vc_hist[$];
  bit hc_hist[$];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // cfg bit k is the bit shifted k shifts ago; missing history reads as 0.
  function automatic logic [3:0] exp_cfg(input int ch);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (ch == 0) begin
        if (k < vc_hist.size()) r[k] = vc_hist[vc_hist.size() - 1 - k];
      end else begin
        if (k < hc_hist.size()) r[k] = hc_hist[hc_hist.size() - 1 - k];
      end
    end
    return r;
  endfunction

  // sel[0] picks the "near" side (top/left), sel[1] moves two tracks up.
  function automatic logic exp_tap(input logic [1:0] sel, input logic [3:0] a,
                                   input logic [3:0] b, input int base);
    int idx;
    idx = base + 2 * int'(sel[1]);
    return sel[0] ? a[idx] : b[idx];
  endfunction

  always @(posedge scan_clk) begin
    if (rst) begin
      vc_hist.delete();
      hc_hist.delete();
    end else if (scan_en) begin
      vc_hist.push_back(scan_in_vc);
      hc_hist.push_back(scan_in_hc);
      if (vc_hist.size() > 4) void'(vc_hist.pop_front());
      if (hc_hist.size() > 4) void'(hc_hist.pop_front());
    end
  end

  always @(negedge scan_clk) begin
    if (armed) begin
      logic [3:0] vc;
      logic [3:0] hc;
      vc = exp_cfg(0);
      hc = exp_cfg(1);
      chk("bottom_out", bottom_out, top_in);
      chk("top_out", top_out, bottom_in);
      chk("right_out", right_out, left_in);
      chk("left_out", left_out, right_in);
      chk("scan_out_vc", scan_out_vc, vc[3]);
      chk("scan_out_hc", scan_out_hc, hc[3]);
      chk("left_clb_in1", left_clb_in1, exp_tap(vc[1:0], top_in, bottom_in, 0));
      chk("right_clb_in3", right_clb_in3, exp_tap(vc[3:2], top_in, bottom_in, 1));
      chk("bottom_clb_in0", bottom_clb_in0, exp_tap(hc[1:0], left_in, right_in, 1));
      chk("top_clb_in2", top_clb_in2, exp_tap(hc[3:2], left_in, right_in, 0));
    end
  end

  task automatic tick();
    @(posedge scan_clk);
    #2;
  endtask

  task automatic rand_tracks();
    top_in    = 4'($urandom);
    bottom_in = 4'($urandom);
    left_in   = 4'($urandom);
    right_in  = 4'($urandom);
  endtask

  // Shifts MSB first so the chain ends up holding exactly v / h.
  task automatic shift_both(input logic [3:0] v, input logic [3:0] h);
    for (int k = 3; k >= 0; k--) begin
      scan_en    = 1'b1;
      scan_in_vc = v[k];
      scan_in_hc = h[k];
      rand_tracks();
      tick();
    end
    scan_en    = 1'b0;
    scan_in_vc = 1'b0;
    scan_in_hc = 1'b0;
  endtask

  task automatic set_tracks(input logic [3:0] t, input logic [3:0] b,
                            input logic [3:0] l, input logic [3:0] r);
    top_in    = t;
    bottom_in = b;
    left_in   = l;
    right_in  = r;
    #1;
  endtask

  initial begin
    rst = 1'b1; scan_en = 1'b0; scan_in_vc = 1'b0; scan_in_hc = 1'b0;
    top_in = 4'hA; bottom_in = 4'h5; right_in = 4'h5; left_in = 4'hA;
    tick();
    armed = 1'b1;
    rst   = 1'b0;
    #1;
    chk("rst_scan_out_vc", scan_out_vc, 4'd0);
    chk("rst_scan_out_hc", scan_out_hc, 4'd0);
    chk("rst_left_clb_in1", left_clb_in1, 4'd1);
    chk("rst_right_clb_in3", right_clb_in3, 4'd0);
    chk("rst_bottom_clb_in0", bottom_clb_in0, 4'd0);
    chk("rst_top_clb_in2", top_clb_in2, 4'd1);

    set_tracks(4'h3, 4'hC, 4'h9, 4'h6);
    chk("pt_bottom_out", bottom_out, 4'h3);
    chk("pt_top_out", top_out, 4'hC);
    chk("pt_right_out", right_out, 4'h9);
    chk("pt_left_out", left_out, 4'h6);

    shift_both(4'b1011, 4'b0000);
    set_tracks(4'b0100, 4'b0000, 4'h0, 4'h0);
    chk("so_left_top2", left_clb_in1, 4'd1);
    chk("so_right_bot3_lo", right_clb_in3, 4'd0);
    set_tracks(4'b0000, 4'b1000, 4'h0, 4'h0);
    chk("so_left_top2_lo", left_clb_in1, 4'd0);
    chk("so_right_bot3", right_clb_in3, 4'd1);
    set_tracks(4'h3, 4'hC, 4'h9, 4'h6);
    chk("pt_cfg_bottom_out", bottom_out, 4'h3);
    chk("pt_cfg_left_out", left_out, 4'h6);

    for (int s = 0; s < 16; s++) begin
      shift_both(4'(s), 4'(15 - s));
      for (int c = 0; c < 20; c++) begin
        rand_tracks();
        tick();
      end
    end

    // Lone 1 followed by zeros: visible on scan_out only after its 4th edge.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      scan_en    = 1'b1;
      scan_in_vc = 1'b0;
      scan_in_hc = (e == 1);
      tick();
      chk("chain_out_hc", scan_out_hc, (e == 4) ? 4'd1 : 4'd0);
    end
    scan_en = 1'b0;
    tick();
    chk("chain_out_hc_hold", scan_out_hc, 4'd0);

    shift_both(4'b0000, 4'b0000);
    scan_en = 1'b1; scan_in_vc = 1'b1; scan_in_hc = 1'b1; tick(); tick();
    scan_en = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_vc", scan_out_vc, 4'd0);
    shift_both(4'b1011, 4'b0110);
    chk("fresh_scan_out_vc", scan_out_vc, 4'd1);
    chk("fresh_scan_out_hc", scan_out_hc, 4'd0);
    set_tracks(4'b0100, 4'b1000, 4'b0001, 4'b1000);
    chk("fresh_left", left_clb_in1, 4'd1);
    chk("fresh_right", right_clb_in3, 4'd1);
    chk("fresh_bottom", bottom_clb_in0, 4'd1);
    chk("fresh_top", top_clb_in2, 4'd1);
    set_tracks(4'b1011, 4'b0111, 4'b1110, 4'b0111);
    chk("fresh_left_lo", left_clb_in1, 4'd0);
    chk("fresh_right_lo", right_clb_in3, 4'd0);
    chk("fresh_bottom_lo", bottom_clb_in0, 4'd0);
    chk("fresh_top_lo", top_clb_in2, 4'd0);

    for (int c = 0; c < 1500; c++) begin
      rst        = ($urandom_range(0, 39) == 0);
      scan_en    = 1'($urandom_range(0, 1));
      scan_in_vc = 1'($urandom_range(0, 1));
      scan_in_hc = 1'($urandom_range(0, 1));
      rand_tracks();
      tick();
    end
    rst = 1'b0; scan_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
